// File: rtl/mux_scan_controller.sv
// mux_scan_controller
//   Steps the select lines of a mux_4x1-style datapath through every index,
//   samples the combinational mux output F once per index, and hands the
//   assembled word downstream through a valid/ready handshake.
//   Optional compare against an expected word: define MUX_SCAN_CHECK_EN.
module mux_scan_controller #(
    parameter int NSEL   = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [NSEL-1:0]      s,
    input  logic                 F,
    output logic [2**NSEL-1:0]   data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef MUX_SCAN_CHECK_EN
    input  logic [2**NSEL-1:0]   exp_i,
    output logic                 mismatch,
`endif
    output logic                 busy
);

    localparam int              N        = 2**NSEL;
    localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
    localparam logic [NSEL-1:0] S_LAST   = NSEL'(N-1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NSEL-1:0] s_q, s_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [N-1:0]    cap_q, cap_d;
    logic [N-1:0]    data_out_q, data_out_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
`ifdef MUX_SCAN_CHECK_EN
    logic [N-1:0]    exp_q, exp_d;
    logic            mismatch_q, mismatch_d;
`endif

    // State register and all datapath/control flops; reset aborts any scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            cnt_q       <= '0;
            cap_q       <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MUX_SCAN_CHECK_EN
            exp_q       <= '0;
            mismatch_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef MUX_SCAN_CHECK_EN
            exp_q       <= exp_d;
            mismatch_q  <= mismatch_d;
`endif
        end
    end

    // Next-state logic: hold each select for SETTLE+1 cycles, sample F on the
    // last cycle of the hold window, publish the word after the final index.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
`ifdef MUX_SCAN_CHECK_EN
        exp_d       = exp_q;
        mismatch_d  = mismatch_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    s_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
`ifdef MUX_SCAN_CHECK_EN
                    exp_d   = exp_i;
`endif
                end
            end
            DRIVE: begin
                if (cnt_q != SETTLE_C) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    cnt_d      = '0;
                    cap_d[s_q] = F;
                    if (s_q == S_LAST) begin
                        // cap_d already carries the final sample in its top bit
                        data_out_d  = cap_d;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b0;
                        s_d         = '0;
                        state_d     = DONE;
`ifdef MUX_SCAN_CHECK_EN
                        mismatch_d  = (cap_d != exp_q);
`endif
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
`ifdef MUX_SCAN_CHECK_EN
                    mismatch_d  = 1'b0;
`endif
                    if (start) begin
                        state_d = DRIVE;
                        s_d     = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
`ifdef MUX_SCAN_CHECK_EN
                        exp_d   = exp_i;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = '0;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign s         = s_q;
    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
`ifdef MUX_SCAN_CHECK_EN
    assign mismatch  = mismatch_q;
`endif

endmodule

// File: tb/tb_mux_scan_controller.sv
// Bench for mux_scan_controller with a behavioural mux (F = i[s]).
// Expected words come from a history of the i[] values applied before each
// clock edge: bit k is i[k] as seen on the edge that closes hold window k.
module tb_mux_scan_controller;

    localparam int NSEL   = 2;
    localparam int SETTLE = 1;
    localparam int N      = 2**NSEL;
    localparam int HOLD   = SETTLE + 1;
    localparam int LAT    = N * HOLD;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            out_ready;
    logic            F;
    logic            out_valid;
    logic            busy;
    logic [NSEL-1:0] s;
    logic [N-1:0]    data_out;
    logic [N-1:0]    i_vec;
`ifdef MUX_SCAN_CHECK_EN
    logic [N-1:0]    exp_i;
    logic            mismatch;
`endif

    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] last_result;

    always #5 clk = ~clk;

    assign F = i_vec[s];

    mux_scan_controller #(.NSEL(NSEL), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s         (s),
        .F         (F),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef MUX_SCAN_CHECK_EN
        .exp_i     (exp_i),
        .mismatch  (mismatch),
`endif
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full scan starting from IDLE or from DONE (back-to-back).
    task automatic do_scan(input bit rnd, input logic [N-1:0] fix_i, input logic [N-1:0] fix_exp);
        logic [N-1:0] hist [1:LAT];
        logic [N-1:0] expv;
        logic [N-1:0] exp_lat;
        start     = 1'b1;
        out_ready = 1'b1;
        i_vec     = rnd ? N'($urandom) : fix_i;
        exp_lat   = rnd ? N'($urandom) : fix_exp;
`ifdef MUX_SCAN_CHECK_EN
        exp_i     = exp_lat;
`endif
        step();
        start     = 1'b0;
        out_ready = 1'b0;
        chk("accept_s", 32'(s), 0);
        chk("accept_busy", 32'(busy), 1);
        chk("accept_valid", 32'(out_valid), 0);
        chk("accept_data_held", 32'(data_out), 32'(last_result));
        for (int j = 1; j <= LAT; j++) begin
            if (rnd) begin
                i_vec     = N'($urandom);
                start     = 1'($urandom);
                out_ready = 1'($urandom);
`ifdef MUX_SCAN_CHECK_EN
                exp_i     = N'($urandom);
`endif
            end
            hist[j] = i_vec;
            step();
            if (j < LAT) begin
                chk("scan_s", 32'(s), 32'(j / HOLD));
                chk("scan_busy", 32'(busy), 1);
                chk("scan_valid", 32'(out_valid), 0);
                chk("scan_data_held", 32'(data_out), 32'(last_result));
`ifdef MUX_SCAN_CHECK_EN
                chk("scan_mismatch", 32'(mismatch), 0);
`endif
            end
        end
        for (int k = 0; k < N; k++) expv[k] = hist[(k + 1) * HOLD][k];
        start     = 1'b0;
        out_ready = 1'b0;
        chk("done_valid", 32'(out_valid), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_s", 32'(s), 0);
        chk("done_data", 32'(data_out), 32'(expv));
`ifdef MUX_SCAN_CHECK_EN
        chk("done_mismatch", 32'(mismatch), 32'(expv != exp_lat));
`endif
        last_result = expv;
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        out_ready   = 1'b0;
        i_vec       = '0;
        last_result = '0;
`ifdef MUX_SCAN_CHECK_EN
        exp_i       = '0;
`endif
        // Reset for two cycles, then release
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_s", 32'(s), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data", 32'(data_out), 0);

        // Basic scan of 1010 from IDLE
        do_scan(1'b0, 4'b1010, 4'b1010);
        chk("scan1010", 32'(data_out), 32'hA);

        // Backpressure: start pulses ignored while out_ready is low
        for (int c = 0; c < 5; c++) begin
            start     = c[0];
            out_ready = 1'b0;
            step();
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data", 32'(data_out), 32'hA);
            chk("bp_s", 32'(s), 0);
            chk("bp_busy", 32'(busy), 0);
        end
        start = 1'b0;

        // Back-to-back scan of 0111 straight from DONE
        do_scan(1'b0, 4'b0111, 4'b0111);
        chk("scan0111", 32'(data_out), 32'h7);

        // Handshake back to IDLE, then sit idle
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hs_valid", 32'(out_valid), 0);
        chk("hs_busy", 32'(busy), 0);
        chk("hs_data_held", 32'(data_out), 32'h7);
        step();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_s", 32'(s), 0);

        // Reset in the middle of a scan takes effect immediately
        i_vec = 4'b0101;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        chk("arst_s", 32'(s), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_data", 32'(data_out), 0);
        step();
        rst = 1'b0;
        step();
        last_result = '0;
        do_scan(1'b0, 4'b1100, 4'b1100);
        chk("scan1100", 32'(data_out), 32'hC);

`ifdef MUX_SCAN_CHECK_EN
        do_scan(1'b0, 4'b1011, 4'b1010);
        chk("cmp_mismatch_hi", 32'(mismatch), 1);
        do_scan(1'b0, 4'b1010, 4'b1010);
        chk("cmp_mismatch_lo", 32'(mismatch), 0);
`endif

        // Randomised scans with changing i[], random backpressure and gaps
        for (int r = 0; r < 20; r++) begin
            do_scan(1'b1, '0, '0);
            for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
                start     = 1'($urandom);
                out_ready = 1'b0;
                step();
                chk("rbp_valid", 32'(out_valid), 1);
                chk("rbp_data", 32'(data_out), 32'(last_result));
                chk("rbp_s", 32'(s), 0);
            end
            start = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                out_ready = 1'b1;
                step();
                out_ready = 1'b0;
                chk("rhs_valid", 32'(out_valid), 0);
                chk("rhs_busy", 32'(busy), 0);
`ifdef MUX_SCAN_CHECK_EN
                chk("rhs_mismatch", 32'(mismatch), 0);
`endif
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
